dmem_arbiter: RTL

Arbiter and sequencer for the single-port data memory of the pipelined CPU. It shares the memory between the MEM-stage access port and a debug/loader port, drives a variable-latency memory handshake, and holds the pipeline through `cpu_stall_o` until the CPU access completes. A watchdog aborts accesses that receive no acknowledge, and a counter tracks stall cycles for the bench.

---
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter and sequencer for the CPU MEM stage and the debug/loader port.
// Latency: a request seen in IDLE in cycle N drives mem_en_o from N+1; completion follows mem_ack_i or a watchdog abort.
// Backpressure: the CPU is held through combinational cpu_stall_o; the debug port waits for a one-cycle dbg_ack_o.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata_i      MEM-stage access request and operands
//   cpu_rdata_o, cpu_stall_o     load data (valid in the completion cycle, then held) and pipeline hold
//   dbg_req/we/addr/wdata_i      debug/loader access request and operands
//   dbg_rdata_o, dbg_ack_o       registered read data and completion pulse, one cycle after the memory ack
//   mem_en/we/addr/wdata_o       memory strobes and operands, stable for the whole access
//   mem_rdata_i, mem_ack_i       memory read data and completion pulse
//   err_o                        one-cycle pulse when the watchdog aborts an access
//   stall_cnt_o                  free-running count of cycles with cpu_stall_o high

module dmem_arbiter #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 16   // legal range 1..255
) (
   input  logic          clk_i,
   input  logic          rst_i,

   input  logic          cpu_req_i,
   input  logic          cpu_we_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic [DW-1:0] cpu_wdata_i,
   output logic [DW-1:0] cpu_rdata_o,
   output logic          cpu_stall_o,

   input  logic          dbg_req_i,
   input  logic          dbg_we_i,
   input  logic [AW-1:0] dbg_addr_i,
   input  logic [DW-1:0] dbg_wdata_i,
   output logic [DW-1:0] dbg_rdata_o,
   output logic          dbg_ack_o,

   output logic          mem_en_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i,
   input  logic          mem_ack_i,

   output logic          err_o,
   output logic [31:0]   stall_cnt_o
);

   // Watchdog terminal value: the counter reads 0 in the first access cycle,
   // so matching TIMEOUT-1 puts the abort exactly TIMEOUT cycles after the
   // request was seen in IDLE.
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CPU  = 2'd1,
      ST_DBG  = 2'd2
   } state_t;

   state_t        state;
   logic          last_dbg;      // 1 when the debug port won the most recent grant
   logic [7:0]    wd_cnt;
   logic [DW-1:0] cpu_rdata_q;   // last value delivered to the CPU

   logic          busy;
   logic          abort;
   logic          done;
   logic          cpu_done;
   logic          grant_cpu;
   logic          grant_dbg;
   logic [DW-1:0] done_rdata;

   assign busy  = (state == ST_CPU) || (state == ST_DBG);

   // An ack in the terminal watchdog cycle wins over the abort.
   assign abort = busy && (wd_cnt == WD_LAST) && !mem_ack_i;
   assign done  = busy && (mem_ack_i || abort);

   // Aborted accesses return zero rather than whatever is on the bus.
   assign done_rdata = mem_ack_i ? mem_rdata_i : '0;

   assign cpu_done = (state == ST_CPU) && done;

   // Round-robin on a tie: the port that did not win last time goes first.
   assign grant_cpu = cpu_req_i && (!dbg_req_i || last_dbg);
   assign grant_dbg = dbg_req_i && !grant_cpu;

   // Combinational so the pipeline advances in the completion cycle itself;
   // a request that was dropped mid-access is never stalled.
   assign cpu_stall_o = cpu_req_i && !cpu_done;
   assign cpu_rdata_o = cpu_done ? done_rdata : cpu_rdata_q;
   assign err_o       = abort;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= ST_IDLE;
         last_dbg    <= 1'b1;    // CPU wins the first tie after reset
         wd_cnt      <= 8'd0;
         mem_en_o    <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_o <= '0;
         dbg_ack_o   <= 1'b0;
         stall_cnt_o <= 32'd0;
      end else begin
         dbg_ack_o   <= 1'b0;
         stall_cnt_o <= stall_cnt_o + 32'(cpu_stall_o);

         case (state)
            ST_IDLE: begin
               // mem_ack_i is deliberately ignored here.
               if (grant_cpu) begin
                  state       <= ST_CPU;
                  last_dbg    <= 1'b0;
                  wd_cnt      <= 8'd0;
                  mem_en_o    <= 1'b1;
                  mem_we_o    <= cpu_we_i;
                  mem_addr_o  <= cpu_addr_i;
                  mem_wdata_o <= cpu_wdata_i;
               end else if (grant_dbg) begin
                  state       <= ST_DBG;
                  last_dbg    <= 1'b1;
                  wd_cnt      <= 8'd0;
                  mem_en_o    <= 1'b1;
                  mem_we_o    <= dbg_we_i;
                  mem_addr_o  <= dbg_addr_i;
                  mem_wdata_o <= dbg_wdata_i;
               end
            end

            ST_CPU, ST_DBG: begin
               wd_cnt <= wd_cnt + 8'd1;
               if (done) begin
                  state    <= ST_IDLE;
                  mem_en_o <= 1'b0;
                  mem_we_o <= 1'b0;
                  // Address and write data are left as they were; nothing
                  // downstream looks at them while mem_en_o is low.
                  if (state == ST_CPU) begin
                     cpu_rdata_q <= done_rdata;
                  end else if (dbg_req_i) begin
                     // A debug request withdrawn mid-access still finishes on
                     // the bus but gets no completion.
                     dbg_rdata_o <= done_rdata;
                     dbg_ack_o   <= 1'b1;
                  end
               end
            end

            default: begin
               state    <= ST_IDLE;
               mem_en_o <= 1'b0;
               mem_we_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
